// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with next-PC selection and a small
// return-address stack used for jal / jr $ra prediction.
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter int               STEP       = 4,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] ras_push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic             misaligned,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] ras_count;

    logic             do_push;
    logic             do_replace;
    logic             do_pop;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign pc_out       = pc_q;
    assign misaligned   = |pc_q[1:0];
    assign ras_empty    = (ras_count == '0);
    assign ras_full     = (ras_count == DEPTH_CNT);
    assign ras_top      = ras_empty ? RESET_PC : ras_mem[top_ptr];

    // Next-PC selection: exceptions and ERET beat stall; a redirect under stall is dropped.
    always_comb begin
        pc_next = pc_plus_step;
        if (exc_req) begin
            pc_next = EXC_VECTOR;
        end else if (eret_req) begin
            pc_next = epc_in;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // Decode RAS operation; push+pop on an empty stack degrades to a plain push.
    always_comb begin
        do_push    = ras_push && (!ras_pop || ras_empty);
        do_replace = ras_push && ras_pop && !ras_empty;
        do_pop     = ras_pop && !ras_push && !ras_empty;
        wr_en      = reset_n && (do_push || do_replace);
        wr_idx     = do_push ? top_ptr + 1'b1 : top_ptr;
    end

    // RAS pointer and occupancy; a push when full wraps over the oldest entry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            top_ptr   <= '0;
            ras_count <= '0;
        end else if (do_push) begin
            top_ptr <= top_ptr + 1'b1;
            if (!ras_full) begin
                ras_count <= ras_count + 1'b1;
            end
        end else if (do_pop) begin
            top_ptr   <= top_ptr - 1'b1;
            ras_count <= ras_count - 1'b1;
        end
    end

    // RAS entry storage; contents need no reset because occupancy masks them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_idx] <= ras_push_addr;
        end
    end

endmodule
